// File: rtl/instr_buffer.sv
// instr_buffer: circular instruction queue between fetch and decode.
//
// Fetch delivers up to FETCH_WIDTH slots per cycle. Only the leading run of
// valid slots is accepted, and only as far as there is free space. Decode
// sees the oldest DECODE_WIDTH entries combinationally and takes as many as
// are present unless it stalls.
//
// Slot packing, for both frontend_instr_i and backend_instr_o:
//   slot i occupies bits [i*65 +: 65] = {valid, pc[31:0], instr[31:0]}
//
// Ports
//   clk                 clock; all state updates on its rising edge
//   rst_n               synchronous active-low reset
//   frontend_instr_i    FETCH_WIDTH packed slots from fetch
//   frontend_stallreq_o asks fetch to stop (free space < 2*FETCH_WIDTH)
//   backend_stall_i     decode cannot accept this cycle
//   backend_flush_i     drop everything buffered and incoming
//   backend_instr_o     DECODE_WIDTH packed slots, oldest first
//
// BUFFER_DEPTH must be a power of 2 and at least 2*FETCH_WIDTH.
module instr_buffer #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [FETCH_WIDTH*65-1:0]   frontend_instr_i,
    output logic                        frontend_stallreq_o,
    input  logic                        backend_stall_i,
    input  logic                        backend_flush_i,
    output logic [DECODE_WIDTH*65-1:0]  backend_instr_o
);

    localparam int SLOT_W = 65;
    localparam int PTR_W  = $clog2(BUFFER_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(2 * FETCH_WIDTH);
    localparam logic [CNT_W-1:0] DEC_W_C  = CNT_W'(DECODE_WIDTH);

    logic [31:0]      pc_q    [BUFFER_DEPTH];
    logic [31:0]      instr_q [BUFFER_DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] n_in, n_wr, n_out, free_sp;
    logic             run;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             wr_en   [BUFFER_DEPTH];
    logic [31:0]      wr_pc   [BUFFER_DEPTH];
    logic [31:0]      wr_ins  [BUFFER_DEPTH];

    // Free space uses the count before this cycle's dequeue, so a full buffer
    // refuses a group even while decode drains it.
    assign free_sp             = DEPTH_C - count_q;
    assign frontend_stallreq_o = (free_sp < MARGIN_C);

    // Leading run of valid slots; anything after the first hole is ignored.
    always_comb begin
        n_in = '0;
        run  = 1'b1;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (run && frontend_instr_i[i*SLOT_W+64]) begin
                n_in = n_in + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        n_wr = (n_in < free_sp) ? n_in : free_sp;
    end

    always_comb begin
        if (backend_stall_i) begin
            n_out = '0;
        end else if (count_q < DEC_W_C) begin
            n_out = count_q;
        end else begin
            n_out = DEC_W_C;
        end
    end

    // Scatter accepted slots onto their destination entries.
    always_comb begin
        wr_idx = '0;
        for (int e = 0; e < BUFFER_DEPTH; e++) begin
            wr_en[e]  = 1'b0;
            wr_pc[e]  = '0;
            wr_ins[e] = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CNT_W'(i) < n_wr) begin
                wr_idx         = wptr_q + PTR_W'(i);
                wr_en[wr_idx]  = 1'b1;
                wr_pc[wr_idx]  = frontend_instr_i[i*SLOT_W+32 +: 32];
                wr_ins[wr_idx] = frontend_instr_i[i*SLOT_W +: 32];
            end
        end
    end

    always_comb begin
        rptr_d  = rptr_q + n_out[PTR_W-1:0];
        wptr_d  = wptr_q + n_wr[PTR_W-1:0];
        count_d = count_q + n_wr - n_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || backend_flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Flush leaves stale entry contents behind; count=0 hides them.
    always_ff @(posedge clk) begin
        for (int e = 0; e < BUFFER_DEPTH; e++) begin
            if (!rst_n) begin
                pc_q[e]    <= '0;
                instr_q[e] <= '0;
            end else if (!backend_flush_i && wr_en[e]) begin
                pc_q[e]    <= wr_pc[e];
                instr_q[e] <= wr_ins[e];
            end
        end
    end

    always_comb begin
        backend_instr_o = '0;
        rd_idx          = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            rd_idx = rptr_q + PTR_W'(k);
            if ((count_q > CNT_W'(k)) && !backend_flush_i) begin
                backend_instr_o[k*SLOT_W +: SLOT_W] = {1'b1, pc_q[rd_idx], instr_q[rd_idx]};
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer with a scoreboard: the driver pushes the
// pcs it expects to be accepted; a negedge monitor compares the presented
// slots against the queue head and pops what decode consumes.
module tb_instr_buffer;

    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [259:0] fe;
    logic         stallreq;
    logic         stall;
    logic         flush;
    logic [129:0] be;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    logic mon_en = 1'b0;
    logic [31:0] q[$];

    instr_buffer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frontend_instr_i    (fe),
        .frontend_stallreq_o (stallreq),
        .backend_stall_i     (stall),
        .backend_flush_i     (flush),
        .backend_instr_o     (be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] spc(input int k);
        return be[k*65+32 +: 32];
    endfunction

    function automatic logic sv(input int k);
        return be[k*65+64];
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        int exp_nv;
        int dut_nv;
        if (mon_en) begin
            exp_nv = flush ? 0 : ((q.size() > 2) ? 2 : q.size());
            chk("stallreq", {31'd0, stallreq}, {31'd0, (16 - q.size()) < 8});
            dut_nv = 0;
            for (int k = 0; k < 2; k++) begin
                if (k < exp_nv) begin
                    chk("slot_valid", {31'd0, be[k*65+64]}, 32'd1);
                    chk("slot_pc", be[k*65+32 +: 32], q[k]);
                    chk("slot_instr", be[k*65 +: 32], q[k] ^ IMASK);
                end else begin
                    chk("slot_zero", {31'd0, |be[k*65 +: 65]}, 32'd0);
                end
                if (be[k*65+64]) dut_nv++;
            end
            if (!stall && !flush) begin
                n_pop += dut_nv;
                for (int k = 0; k < exp_nv; k++) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cycle(input logic [3:0] vm, input logic [31:0] base,
                         input logic st, input logic fl, input logic rs);
        int n_in;
        int nacc;
        int free_sp;
        logic [31:0] pend[$];
        for (int i = 0; i < 4; i++) begin
            fe[i*65 +: 65] = {vm[i], base + 32'(4*i), (base + 32'(4*i)) ^ IMASK};
        end
        stall = st;
        flush = fl;
        rst_n = rs;
        n_in = 0;
        for (int i = 0; i < 4; i++) if (vm[i] && n_in == i) n_in++;
        free_sp = 16 - q.size();
        nacc = (n_in < free_sp) ? n_in : free_sp;
        for (int i = 0; i < nacc; i++) pend.push_back(base + 32'(4*i));
        if (fl) begin
            #1;
            chk("flush_cycle_v0", {31'd0, sv(0)}, 32'd0);
            chk("flush_cycle_v1", {31'd0, sv(1)}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (!rs || fl) q.delete();
        else foreach (pend[i]) q.push_back(pend[i]);
        fe = '0;
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 12; c++) cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("drained_empty", {31'd0, sv(0)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int pop0;
        logic [15:0] stpat;
        stpat = 16'b0110_1100_0011_1010;
        rst_n = 1'b0;
        fe    = '0;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_stallreq", {31'd0, stallreq}, 32'd0);
        chk("reset_v0", {31'd0, sv(0)}, 32'd0);
        chk("reset_bus", {31'd0, |be}, 32'd0);

        // Basic flow
        cycle(4'hF, 32'h1c00_0000, 1'b0, 1'b0, 1'b1);
        chk("basic_pc0", spc(0), 32'h1c00_0000);
        chk("basic_pc1", spc(1), 32'h1c00_0004);
        cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("basic_pc2", spc(0), 32'h1c00_0008);
        chk("basic_pc3", spc(1), 32'h1c00_000c);
        cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("basic_empty", {31'd0, sv(0)}, 32'd0);

        // Non-prefix valid 1,1,0,1: only two accepted
        cycle(4'b1011, 32'h2000, 1'b1, 1'b0, 1'b1);
        chk("prefix_pc0", spc(0), 32'h2000);
        chk("prefix_pc1", spc(1), 32'h2004);
        cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("prefix_after_drain", {31'd0, sv(0)}, 32'd0);

        // Fill under stall: stallreq at 12, full at 16, extra groups dropped
        cycle(4'hF, 32'h3000, 1'b1, 1'b0, 1'b1);
        chk("fill_sr_4", {31'd0, stallreq}, 32'd0);
        cycle(4'hF, 32'h3010, 1'b1, 1'b0, 1'b1);
        chk("fill_sr_8", {31'd0, stallreq}, 32'd0);
        cycle(4'hF, 32'h3020, 1'b1, 1'b0, 1'b1);
        chk("fill_sr_12", {31'd0, stallreq}, 32'd1);
        cycle(4'hF, 32'h3030, 1'b1, 1'b0, 1'b1);
        chk("fill_sr_16", {31'd0, stallreq}, 32'd1);
        cycle(4'hF, 32'h3040, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h3050, 1'b1, 1'b0, 1'b1);
        chk("full_head", spc(0), 32'h3000);
        drain();

        // Partial acceptance: count 14, group of 4 keeps only 2
        cycle(4'hF, 32'h3100, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h3110, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h3120, 1'b1, 1'b0, 1'b1);
        cycle(4'b0011, 32'h3130, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h3140, 1'b1, 1'b0, 1'b1);
        drain();

        // Wrap-around with mixed stalls, fetch honouring free space
        g = 0;
        pop0 = n_pop;
        for (int c = 0; c < 100 && (g < 10 || q.size() != 0); c++) begin
            if (g < 10 && (16 - q.size()) >= 8) begin
                cycle(4'hF, 32'h4000 + 32'(16*g), stpat[c%16], 1'b0, 1'b1);
                g++;
            end else begin
                cycle(4'h0, 32'h0, stpat[c%16], 1'b0, 1'b1);
            end
        end
        chk("wrap_popped", 32'(n_pop - pop0), 32'd40);
        drain();

        // Simultaneous enqueue and dequeue from count 1 -> 1+4-1 = 4
        cycle(4'b0001, 32'h5000, 1'b1, 1'b0, 1'b1);
        chk("simul_pre", spc(0), 32'h5000);
        cycle(4'hF, 32'h5100, 1'b0, 1'b0, 1'b1);
        chk("simul_pc0", spc(0), 32'h5100);
        chk("simul_pc1", spc(1), 32'h5104);
        cycle(4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        drain();

        // Flush with count 10 and a valid group
        cycle(4'hF, 32'h6000, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h6010, 1'b1, 1'b0, 1'b1);
        cycle(4'b0011, 32'h6020, 1'b1, 1'b0, 1'b1);
        chk("flush_pre_sr", {31'd0, stallreq}, 32'd1);
        cycle(4'hF, 32'h6100, 1'b0, 1'b1, 1'b1);
        chk("flush_post_v0", {31'd0, sv(0)}, 32'd0);
        chk("flush_post_sr", {31'd0, stallreq}, 32'd0);
        cycle(4'hF, 32'h6200, 1'b0, 1'b0, 1'b1);
        chk("flush_refill", spc(0), 32'h6200);
        drain();

        // Same with reset instead of flush
        cycle(4'hF, 32'h7000, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h7010, 1'b1, 1'b0, 1'b1);
        cycle(4'b0011, 32'h7020, 1'b1, 1'b0, 1'b1);
        cycle(4'hF, 32'h7100, 1'b0, 1'b0, 1'b0);
        chk("rst_post_v0", {31'd0, sv(0)}, 32'd0);
        chk("rst_post_bus", {31'd0, |be}, 32'd0);
        chk("rst_post_sr", {31'd0, stallreq}, 32'd0);
        cycle(4'hF, 32'h7200, 1'b0, 1'b0, 1'b1);
        chk("rst_refill", spc(0), 32'h7200);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
